rom_arbiter: RTL and testbench

//  Shares the single-port waveform ROM (11-bit address, 8-bit data) between two read requesters.

---
 rtl/rom_arbiter.sv | 69 ++++++
 tb/tb_rom_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin share of one single-port ROM between two readers; one access per cycle, no backpressure.
// Data returns ROM_LATENCY+1 cycles after the grant, in grant order, flagged by a per-requester valid pulse.
module rom_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);
    localparam int DEPTH = ROM_LATENCY + 1;

    logic             last_gnt;
    logic             win_vld;
    logic             win_id;
    logic [DEPTH-1:0] pipe_vld;
    logic [DEPTH-1:0] pipe_id;
    logic             ret_vld;
    logic             ret_id;

    always_comb begin
        win_vld = req0 | req1;
        // On a tie the requester that did not win last time goes; otherwise whoever asks.
        win_id  = (req0 & req1) ? ~last_gnt : req1;
        ret_vld = pipe_vld[DEPTH-1];
        ret_id  = pipe_id[DEPTH-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rom_addr <= '0;
            last_gnt <= 1'b1;
            pipe_vld <= '0;
            pipe_id  <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            gnt0 <= win_vld & ~win_id;
            gnt1 <= win_vld & win_id;
            if (win_vld) begin
                rom_addr <= win_id ? addr1 : addr0;
                last_gnt <= win_id;
            end
            // Stage 0 is loaded on the grant edge; the last stage lines up with valid rom_q.
            pipe_vld <= {pipe_vld[DEPTH-2:0], win_vld};
            pipe_id  <= {pipe_id[DEPTH-2:0], win_id};
            rvalid0  <= ret_vld & ~ret_id;
            rvalid1  <= ret_vld & ret_id;
            if (ret_vld && !ret_id) rdata0 <= rom_q;
            if (ret_vld && ret_id)  rdata1 <= rom_q;
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Drives two arbiters (ROM latency 1 and 2) with the same stimulus and scores them against a
// cycle-scheduled reference model over a shared ROM image.
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [10:0] addr0 = '0, addr1 = '0;

    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a;
    logic [7:0]  rdata0_a, rdata1_a, rom_q_a;
    logic [10:0] rom_addr_a;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
    logic [7:0]  rdata0_b, rdata1_b, rom_q_b, rom_q_b0;
    logic [10:0] rom_addr_b;

    logic [7:0]  mem [0:2047];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a)
    );

    rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LATENCY(2)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b)
    );

    // Synchronous ROMs with 1 and 2 edges of read latency.
    always @(posedge clk) begin
        rom_q_a  <= mem[rom_addr_a];
        rom_q_b0 <= mem[rom_addr_b];
        rom_q_b  <= rom_q_b0;
    end

    // Reference model: each grant schedules a delivery at cycle (grant + latency + 1).
    int          cyc;
    int          last_m [2];
    logic [1:0]  e_gnt  [2];
    logic [1:0]  e_rv   [2];
    logic [7:0]  e_rd   [2][2];
    logic [10:0] e_addr [2];
    logic        pend_v    [2][8];
    logic        pend_id   [2][8];
    logic [10:0] pend_addr [2][8];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_m[k] = 1;
            e_gnt[k]  = '0;
            e_rv[k]   = '0;
            e_rd[k][0] = '0;
            e_rd[k][1] = '0;
            e_addr[k] = '0;
            for (int s = 0; s < 8; s++) pend_v[k][s] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int slot, win, s, id;
        slot = cyc % 8;
        for (int k = 0; k < 2; k++) begin
            e_gnt[k] = '0;
            e_rv[k]  = '0;
            if (pend_v[k][slot]) begin
                id = int'(pend_id[k][slot]);
                e_rv[k][id] = 1'b1;
                e_rd[k][id] = mem[pend_addr[k][slot]];
                pend_v[k][slot] = 1'b0;
            end
            win = -1;
            if (req0 && req1)  win = (last_m[k] == 0) ? 1 : 0;
            else if (req0)     win = 0;
            else if (req1)     win = 1;
            if (win >= 0) begin
                last_m[k] = win;
                e_gnt[k][win] = 1'b1;
                e_addr[k] = (win == 1) ? addr1 : addr0;
                s = (cyc + k + 2) % 8;
                pend_v[k][s]    = 1'b1;
                pend_id[k][s]   = (win == 1);
                pend_addr[k][s] = e_addr[k];
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("a.gnt",    {14'd0, gnt1_a, gnt0_a},       {14'd0, e_gnt[0]});
        chk("a.rvalid", {14'd0, rvalid1_a, rvalid0_a}, {14'd0, e_rv[0]});
        chk("a.rdata0", {8'd0, rdata0_a},              {8'd0, e_rd[0][0]});
        chk("a.rdata1", {8'd0, rdata1_a},              {8'd0, e_rd[0][1]});
        chk("a.rom_addr", {5'd0, rom_addr_a},          {5'd0, e_addr[0]});
        chk("b.gnt",    {14'd0, gnt1_b, gnt0_b},       {14'd0, e_gnt[1]});
        chk("b.rvalid", {14'd0, rvalid1_b, rvalid0_b}, {14'd0, e_rv[1]});
        chk("b.rdata0", {8'd0, rdata0_b},              {8'd0, e_rd[1][0]});
        chk("b.rdata1", {8'd0, rdata1_b},              {8'd0, e_rd[1][1]});
        chk("b.rom_addr", {5'd0, rom_addr_b},          {5'd0, e_addr[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic r0, input logic [10:0] a0, input logic r1, input logic [10:0] a1);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    endtask

    // Reset is asserted mid-cycle and held across one rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        cyc = 0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all();

        // Single read of address 5, then idle while it returns.
        drive(1'b1, 11'h005, 1'b0, 11'h000);
        step();
        drive(1'b0, 11'h005, 1'b0, 11'h000);
        repeat (4) step();

        // Contention: strict alternation, returns in grant order.
        drive(1'b1, 11'h010, 1'b1, 11'h7FF);
        repeat (6) step();
        drive(1'b0, 11'h010, 1'b0, 11'h7FF);
        repeat (4) step();

        // Requester 1 streams addresses 0..7 back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 11'h000, 1'b1, 11'(i));
            step();
        end
        drive(1'b0, 11'h000, 1'b0, 11'h000);
        repeat (4) step();

        // Reset while a read is in flight: it must never be delivered.
        drive(1'b1, 11'h123, 1'b0, 11'h000);
        step();
        drive(1'b0, 11'h123, 1'b0, 11'h000);
        do_reset();
        repeat (4) step();
        drive(1'b1, 11'h0AA, 1'b1, 11'h055);
        repeat (3) step();

        // One-cycle pulse then idle: rom_addr must hold.
        drive(1'b1, 11'h3C3, 1'b0, 11'h000);
        step();
        drive(1'b0, 11'h000, 1'b0, 11'h111);
        repeat (5) step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom));
            step();
        end
        drive(1'b0, 11'h000, 1'b0, 11'h000);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
